// File: rtl/sha2_compress_core.sv
// SHA-2 compression engine: one round per clock over a..h, with the digest registers,
// block chaining and feed-forward add held internally. WORD_W=32 is SHA-256, 64 is SHA-512.
module sha2_compress_core #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                first_block_i,
  input  logic [8*WORD_W-1:0] h_init_i,
  input  logic [WORD_W-1:0]   w_in_i,
  input  logic [WORD_W-1:0]   k_in_i,
  output logic [IDX_W-1:0]    round_idx_o,
  output logic                ready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [8*WORD_W-1:0] digest_o
);

  if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_cfg
    $error("sha2_compress_core: WORD_W/ROUNDS must be 32/64 or 64/80");
  end
  if ((2 ** IDX_W) < ROUNDS) begin : g_bad_idx
    $error("sha2_compress_core: IDX_W too narrow for ROUNDS");
  end

  localparam int S0_A = (WORD_W == 64) ? 28 : 2;
  localparam int S0_B = (WORD_W == 64) ? 34 : 13;
  localparam int S0_C = (WORD_W == 64) ? 39 : 22;
  localparam int S1_A = (WORD_W == 64) ? 14 : 6;
  localparam int S1_B = (WORD_W == 64) ? 18 : 11;
  localparam int S1_C = (WORD_W == 64) ? 41 : 25;

  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, ROUND, ADD} state_t;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             done_q;
  word_t            work_q [8];
  word_t            hash_q [8];
  word_t            work_d [8];
  word_t            hinit_w [8];
  word_t            sig0, sig1, ch, maj, t1, t2;

  // Word 0 (H0 / a) sits in the MSBs of both the seed input and the digest output.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pack
    assign hinit_w[gi] = h_init_i[(7-gi)*WORD_W +: WORD_W];
    assign digest_o[(7-gi)*WORD_W +: WORD_W] = hash_q[gi];
  end

  always_comb begin
    sig1 = rotr(work_q[4], S1_A) ^ rotr(work_q[4], S1_B) ^ rotr(work_q[4], S1_C);
    ch   = (work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]);
    sig0 = rotr(work_q[0], S0_A) ^ rotr(work_q[0], S0_B) ^ rotr(work_q[0], S0_C);
    maj  = (work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]);
    t1   = work_q[7] + sig1 + ch + k_in_i + w_in_i;
    t2   = sig0 + maj;
    work_d[0] = t1 + t2;
    work_d[1] = work_q[0];
    work_d[2] = work_q[1];
    work_d[3] = work_q[2];
    work_d[4] = work_q[3] + t1;
    work_d[5] = work_q[4];
    work_d[6] = work_q[5];
    work_d[7] = work_q[6];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        work_q[i] <= '0;
        hash_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            for (int i = 0; i < 8; i++) begin
              work_q[i] <= first_block_i ? hinit_w[i] : hash_q[i];
              if (first_block_i) hash_q[i] <= hinit_w[i];
            end
            idx_q   <= '0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          work_q <= work_d;
          // The counter parks on the last index through ADD so upstream can see it.
          if (idx_q == IDX_W'(ROUNDS - 1)) state_q <= ADD;
          else                             idx_q   <= idx_q + IDX_W'(1);
        end
        ADD: begin
          for (int i = 0; i < 8; i++) hash_q[i] <= hash_q[i] + work_q[i];
          idx_q   <= '0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign round_idx_o = idx_q;
  assign ready_o     = (state_q == IDLE);
  assign busy_o      = ~ready_o;
  assign done_o      = done_q;

endmodule

// File: tb/tb_sha2_compress_core.sv
// Bench for sha2_compress_core: SHA-256 and SHA-512 instances driven from a FIPS-style
// reference model (constants derived from prime roots), plus known-answer digests.
module tb_sha2_compress_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start32, first32, ready32, busy32, done32;
  logic [255:0] hinit32, dig32;
  logic [31:0]  w32, k32;
  logic [6:0]   idx32;

  logic         start64, first64, ready64, busy64, done64;
  logic [511:0] hinit64, dig64;
  logic [63:0]  w64, k64;
  logic [6:0]   idx64;

  sha2_compress_core #(.WORD_W(32), .ROUNDS(64), .IDX_W(7)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .first_block_i(first32), .h_init_i(hinit32),
    .w_in_i(w32), .k_in_i(k32), .round_idx_o(idx32), .ready_o(ready32), .busy_o(busy32),
    .done_o(done32), .digest_o(dig32)
  );

  sha2_compress_core #(.WORD_W(64), .ROUNDS(80), .IDX_W(7)) dut64 (
    .clk(clk), .rst(rst), .start_i(start64), .first_block_i(first64), .h_init_i(hinit64),
    .w_in_i(w64), .k_in_i(k64), .round_idx_o(idx64), .ready_o(ready64), .busy_o(busy64),
    .done_o(done64), .digest_o(dig64)
  );

  int checkCount = 0;
  int errorCount = 0;

  logic [63:0]  kTab32 [64];
  logic [63:0]  kTab64 [80];
  logic [63:0]  wSched [80];
  logic [511:0] iv32Model, iv64Model, modelH32, modelH64;
  logic [31:0]  fill32;
  logic [63:0]  fill64;

  localparam logic [255:0] KAT_ABC256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] KAT_TWO256 =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  // Model words are 64-bit, word i at [64*i]; in 32-bit mode only the low half is used.
  function automatic logic [63:0] msk(input bit is64, input logic [63:0] x);
    return is64 ? x : {32'h0, x[31:0]};
  endfunction

  function automatic logic [63:0] rotr(input bit is64, input logic [63:0] x, input int n);
    if (is64) return (x >> n) | (x << (64 - n));
    return msk(1'b0, (x >> n) | (x << (32 - n)));
  endfunction

  function automatic logic [255:0] iroot(input logic [255:0] n, input bit cube);
    logic [255:0] r, t, p;
    r = '0;
    for (int b = 70; b >= 0; b--) begin
      t = r | (256'd1 << b);
      p = cube ? t * t * t : t * t;
      if (p <= n) r = t;
    end
    return r;
  endfunction

  function automatic logic [255:0] model_to_dig32(input logic [511:0] m);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[(7-i)*32 +: 32] = m[64*i +: 32];
    return d;
  endfunction

  function automatic logic [511:0] dig32_to_model(input logic [255:0] d);
    logic [511:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[64*i +: 32] = d[(7-i)*32 +: 32];
    return m;
  endfunction

  function automatic logic [511:0] model_to_dig64(input logic [511:0] m);
    logic [511:0] d;
    for (int i = 0; i < 8; i++) d[(7-i)*64 +: 64] = m[64*i +: 64];
    return d;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1023:0] rand_blk(input bit is64);
    logic [1023:0] b;
    for (int j = 0; j < 16; j++) b[64*j +: 64] = is64 ? {$urandom, $urandom} : {32'h0, $urandom};
    return b;
  endfunction

  task automatic init_tables();
    int primes [80];
    int cnt;
    logic [255:0] tmp;
    cnt = 0;
    for (int n = 2; cnt < 80; n++) begin
      bit isPrime;
      isPrime = 1'b1;
      for (int d = 2; d * d <= n; d++) if (n % d == 0) isPrime = 1'b0;
      if (isPrime) begin
        primes[cnt] = n;
        cnt++;
      end
    end
    for (int i = 0; i < 80; i++) begin
      tmp = iroot(256'(primes[i]) << 192, 1'b1);
      kTab64[i] = tmp[63:0];
    end
    for (int i = 0; i < 64; i++) begin
      tmp = iroot(256'(primes[i]) << 96, 1'b1);
      kTab32[i] = {32'h0, tmp[31:0]};
    end
    for (int i = 0; i < 8; i++) begin
      tmp = iroot(256'(primes[i]) << 64, 1'b0);
      iv32Model[64*i +: 64] = {32'h0, tmp[31:0]};
      tmp = iroot(256'(primes[i]) << 128, 1'b0);
      iv64Model[64*i +: 64] = tmp[63:0];
    end
  endtask

  task automatic build_schedule(input bit is64, input logic [1023:0] blk);
    logic [63:0] s0, s1, x, y;
    for (int t = 0; t < 16; t++) wSched[t] = msk(is64, blk[64*t +: 64]);
    for (int t = 16; t < (is64 ? 80 : 64); t++) begin
      x  = wSched[t-15];
      y  = wSched[t-2];
      s0 = is64 ? rotr(1, x, 1) ^ rotr(1, x, 8) ^ (x >> 7)
                : rotr(0, x, 7) ^ rotr(0, x, 18) ^ (x >> 3);
      s1 = is64 ? rotr(1, y, 19) ^ rotr(1, y, 61) ^ (y >> 6)
                : rotr(0, y, 17) ^ rotr(0, y, 19) ^ (y >> 10);
      wSched[t] = msk(is64, s1 + wSched[t-7] + s0 + wSched[t-16]);
    end
  endtask

  function automatic logic [511:0] ref_compress(input bit is64, input logic [511:0] hin);
    logic [63:0] v [8];
    logic [63:0] bs0, bs1, ch, maj, t1, t2, k;
    logic [511:0] hout;
    for (int i = 0; i < 8; i++) v[i] = hin[64*i +: 64];
    for (int r = 0; r < (is64 ? 80 : 64); r++) begin
      if (is64) k = kTab64[r];
      else      k = kTab32[r];
      bs1 = is64 ? rotr(1, v[4], 14) ^ rotr(1, v[4], 18) ^ rotr(1, v[4], 41)
                 : rotr(0, v[4], 6) ^ rotr(0, v[4], 11) ^ rotr(0, v[4], 25);
      bs0 = is64 ? rotr(1, v[0], 28) ^ rotr(1, v[0], 34) ^ rotr(1, v[0], 39)
                 : rotr(0, v[0], 2) ^ rotr(0, v[0], 13) ^ rotr(0, v[0], 22);
      ch  = msk(is64, (v[4] & v[5]) ^ (~v[4] & v[6]));
      maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t1  = msk(is64, v[7] + bs1 + ch + k + wSched[r]);
      t2  = msk(is64, bs0 + maj);
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4];
      v[4] = msk(is64, v[3] + t1);
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0];
      v[0] = msk(is64, t1 + t2);
    end
    for (int i = 0; i < 8; i++) hout[64*i +: 64] = msk(is64, hin[64*i +: 64] + v[i]);
    return hout;
  endfunction

  // Runs one SHA-256 block from a negedge with ready high; returns at the negedge in
  // the done cycle. abortAt >= 0 pulses reset when round_idx reaches that value.
  task automatic run_block32(input bit first, input logic [255:0] hinit, input logic [1023:0] blk,
                             input int holdStart, input int abortAt);
    logic [511:0] expH;
    build_schedule(1'b0, blk);
    if (first) modelH32 = dig32_to_model(hinit);
    expH = ref_compress(1'b0, modelH32);
    checkCount++;
    if (ready32 !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL ready_before_start: got %b expected 1", ready32);
    end
    start32 = 1'b1; first32 = first; hinit32 = hinit; w32 = fill32; k32 = fill32;
    @(posedge clk); @(negedge clk);
    for (int r = 0; r < 64; r++) begin
      if (r < holdStart) begin
        start32 = 1'b1; first32 = 1'($urandom); hinit32 = rand256();
      end else begin
        start32 = 1'b0;
      end
      checkCount++;
      if (idx32 !== 7'(r)) begin
        errorCount++;
        $display("[TB] FAIL round_idx32: got %0d expected %0d", idx32, r);
      end
      checkCount++;
      if ({ready32, busy32, done32} !== 3'b010) begin
        errorCount++;
        $display("[TB] FAIL flags32_round%0d: got rdy/busy/done=%b expected 010", r, {ready32, busy32, done32});
      end
      if (r == abortAt) begin
        rst = 1'b1;
        #1;
        checkCount++;
        if ({ready32, busy32, done32} !== 3'b100 || idx32 !== 7'd0 || dig32 !== '0) begin
          errorCount++;
          $display("[TB] FAIL reset_midblock: got rdy/busy/done=%b idx=%0d digest=%h expected 100/0/0",
                   {ready32, busy32, done32}, idx32, dig32);
        end
        modelH32 = '0; modelH64 = '0; start32 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      w32 = wSched[r][31:0];
      k32 = kTab32[r][31:0];
      @(posedge clk); @(negedge clk);
    end
    start32 = 1'b0; w32 = fill32; k32 = fill32;
    checkCount++;
    if (idx32 !== 7'd63 || done32 !== 1'b0 || busy32 !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL add_cycle32: got idx=%0d done=%b busy=%b expected 63/0/1", idx32, done32, busy32);
    end
    @(posedge clk); @(negedge clk);
    checkCount++;
    if ({ready32, busy32, done32} !== 3'b101 || idx32 !== 7'd0) begin
      errorCount++;
      $display("[TB] FAIL done_cycle32: got rdy/busy/done=%b idx=%0d expected 101/0", {ready32, busy32, done32}, idx32);
    end
    checkCount++;
    if (dig32 !== model_to_dig32(expH)) begin
      errorCount++;
      $display("[TB] FAIL digest32_model: got %h expected %h", dig32, model_to_dig32(expH));
    end
    modelH32 = expH;
  endtask

  task automatic run_block64(input bit first, input logic [511:0] hinitModel, input logic [1023:0] blk);
    logic [511:0] expH;
    build_schedule(1'b1, blk);
    if (first) modelH64 = hinitModel;
    expH = ref_compress(1'b1, modelH64);
    start64 = 1'b1; first64 = first; hinit64 = model_to_dig64(hinitModel); w64 = fill64; k64 = fill64;
    @(posedge clk); @(negedge clk);
    start64 = 1'b0;
    for (int r = 0; r < 80; r++) begin
      checkCount++;
      if (idx64 !== 7'(r) || busy64 !== 1'b1 || done64 !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL round64: got idx=%0d busy=%b done=%b expected %0d/1/0", idx64, busy64, done64, r);
      end
      w64 = wSched[r]; k64 = kTab64[r];
      @(posedge clk); @(negedge clk);
    end
    w64 = fill64; k64 = fill64;
    @(posedge clk); @(negedge clk);
    checkCount++;
    if (done64 !== 1'b1 || ready64 !== 1'b1 || idx64 !== 7'd0) begin
      errorCount++;
      $display("[TB] FAIL done_cycle64: got done=%b ready=%b idx=%0d expected 1/1/0", done64, ready64, idx64);
    end
    checkCount++;
    if (dig64 !== model_to_dig64(expH)) begin
      errorCount++;
      $display("[TB] FAIL digest64_model: got %h expected %h", dig64, model_to_dig64(expH));
    end
    modelH64 = expH;
  endtask

  function automatic logic [1023:0] abc_blk(input bit is64);
    logic [1023:0] b;
    b = '0;
    b[63:0] = is64 ? 64'h6162638000000000 : 64'h0000000061626380;
    b[64*15 +: 64] = 64'h18;
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start32 = 0; first32 = 0; hinit32 = '0; w32 = '0; k32 = '0;
    start64 = 0; first64 = 0; hinit64 = '0; w64 = '0; k64 = '0;
    modelH32 = '0; modelH64 = '0;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({ready32, busy32, done32} !== 3'b100 || idx32 !== 7'd0 || dig32 !== '0) begin
      errorCount++;
      $display("[TB] FAIL reset32: got rdy/busy/done=%b idx=%0d digest=%h expected 100/0/0", {ready32, busy32, done32}, idx32, dig32);
    end
    checkCount++;
    if ({ready64, busy64, done64} !== 3'b100 || idx64 !== 7'd0 || dig64 !== '0) begin
      errorCount++;
      $display("[TB] FAIL reset64: got rdy/busy/done=%b idx=%0d digest=%h expected 100/0/0", {ready64, busy64, done64}, idx64, dig64);
    end
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if (ready32 !== 1'b1 || dig32 !== '0) begin
      errorCount++;
      $display("[TB] FAIL reset32_release: got ready=%b digest=%h expected 1/0", ready32, dig32);
    end
  endtask

  task automatic test_sha256_abc();
    run_block32(1'b1, model_to_dig32(iv32Model), abc_blk(1'b0), 0, -1);
    checkCount++;
    if (dig32 !== KAT_ABC256) begin
      errorCount++;
      $display("[TB] FAIL kat_abc256: got %h expected %h", dig32, KAT_ABC256);
    end
  endtask

  task automatic test_back_to_back();
    logic [1023:0] b1, b2;
    b1 = '0; b2 = '0;
    for (int j = 0; j < 14; j++)
      b1[64*j +: 32] = {8'h61 + 8'(j), 8'h62 + 8'(j), 8'h63 + 8'(j), 8'h64 + 8'(j)};
    b1[64*14 +: 32] = 32'h80000000;
    b2[64*15 +: 32] = 32'h000001c0;
    run_block32(1'b1, model_to_dig32(iv32Model), b1, 0, -1);
    run_block32(1'b0, rand256(), b2, 0, -1);
    checkCount++;
    if (dig32 !== KAT_TWO256) begin
      errorCount++;
      $display("[TB] FAIL kat_two_block256: got %h expected %h", dig32, KAT_TWO256);
    end
  endtask

  task automatic test_sha512_abc();
    run_block64(1'b1, iv64Model, abc_blk(1'b1));
    checkCount++;
    if (dig64[511:448] !== 64'hddaf35a193617aba || dig64[31:0] !== 32'ha54ca49f) begin
      errorCount++;
      $display("[TB] FAIL kat_abc512: got %h..%h expected ddaf35a193617aba..a54ca49f", dig64[511:448], dig64[31:0]);
    end
  endtask

  task automatic test_start_held();
    int pulses;
    run_block32(1'b1, model_to_dig32(iv32Model), abc_blk(1'b0), 9, -1);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (done32 === 1'b1) pulses++;
    end
    checkCount++;
    if (pulses !== 0 || dig32 !== KAT_ABC256) begin
      errorCount++;
      $display("[TB] FAIL start_held: got extra_done=%0d digest=%h expected 0/%h", pulses, dig32, KAT_ABC256);
    end
  endtask

  task automatic test_reset_midblock();
    run_block32(1'b1, model_to_dig32(iv32Model), abc_blk(1'b0), 0, 30);
    run_block32(1'b1, model_to_dig32(iv32Model), abc_blk(1'b0), 0, -1);
    checkCount++;
    if (dig32 !== KAT_ABC256) begin
      errorCount++;
      $display("[TB] FAIL restart_abc256: got %h expected %h", dig32, KAT_ABC256);
    end
  endtask

  task automatic test_wk_ignored();
    fill32 = 32'hFFFF_FFFF;
    @(negedge clk);
    run_block32(1'b1, model_to_dig32(iv32Model), abc_blk(1'b0), 0, -1);
    checkCount++;
    if (dig32 !== KAT_ABC256) begin
      errorCount++;
      $display("[TB] FAIL wk_ignored: got %h expected %h", dig32, KAT_ABC256);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      fill32 = $urandom;
      run_block32((n == 0) ? 1'b1 : 1'($urandom), rand256(), rand_blk(1'b0), int'($urandom_range(0, 3)), -1);
    end
    fill64 = {$urandom, $urandom};
    run_block64(1'b0, {rand256(), rand256()}, rand_blk(1'b1));
  endtask

  task automatic test_chain_from_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelH32 = '0; modelH64 = '0;
    @(negedge clk);
    run_block32(1'b0, rand256(), rand_blk(1'b0), 0, -1);
    run_block64(1'b0, {rand256(), rand256()}, rand_blk(1'b1));
  endtask

  initial begin
    fill32 = 32'h0; fill64 = 64'h0;
    init_tables();
    test_reset();
    test_sha256_abc();
    test_back_to_back();
    test_sha512_abc();
    test_start_held();
    test_reset_midblock();
    test_wk_ignored();
    test_random();
    test_chain_from_reset();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
